// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command FIFO plus a three-state sequencer in front of a
// combinational 16-bit ALU. Each command is popped, driven to the ALU for one
// cycle, and its result is returned over a valid/ready channel. An accumulator
// holds the last ALU result so a command can chain on the previous one.
// Optional macro ALU_SEQ_STATS_EN adds saturating issued/dropped counters.
`timescale 1ns/1ps

module alu_op_sequencer #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd_opcode,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic         cmd_use_acc,
  output logic [3:0]   alu_opcode,
  output logic [W-1:0] alu_in1,
  output logic [W-1:0] alu_in2,
  input  logic [W-1:0] alu_out,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic [3:0]   res_opcode,
  output logic         res_err
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]  stat_issued,
  output logic [15:0]  stat_dropped
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [3:0] OP_NOOP  = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_DIV   = 4'h4;
  localparam logic [3:0] OP_NOT   = 4'h8;
  localparam logic [3:0] OP_RESET = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t state_q;

  // Command storage; small enough that a combinational head read is cheap and
  // lets IDLE decode the head on the same edge it pops it.
  logic [3:0]   fifo_op_q  [DEPTH];
  logic [W-1:0] fifo_a_q   [DEPTH];
  logic [W-1:0] fifo_b_q   [DEPTH];
  logic         fifo_acc_q [DEPTH];

  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;

  logic [3:0]   head_op;
  logic [W-1:0] head_a;
  logic [W-1:0] head_b;
  logic         head_use_acc;
  logic         head_legal;
  logic         head_div0;
  logic         head_dropped;
  logic [W-1:0] head_in1;

  logic [3:0]   alu_opcode_q;
  logic [W-1:0] alu_in1_q;
  logic [W-1:0] alu_in2_q;
  logic         res_valid_q;
  logic [W-1:0] res_data_q;
  logic [3:0]   res_opcode_q;
  logic         res_err_q;
  logic [W-1:0] acc_q;

  // Readiness looks only at fullness, never at a simultaneous pop.
  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;
  assign pop        = (state_q == ST_IDLE) && !fifo_empty;

  assign head_op      = fifo_op_q[rd_ptr_q];
  assign head_a       = fifo_a_q[rd_ptr_q];
  assign head_b       = fifo_b_q[rd_ptr_q];
  assign head_use_acc = fifo_acc_q[rd_ptr_q];

  // Opcodes the ALU actually executes; NOOP, RESET and 1001-1110 never reach it.
  assign head_legal   = (head_op >= OP_ADD) && (head_op <= OP_NOT);
  assign head_div0    = (head_op == OP_DIV) && (head_b == '0);
  assign head_dropped = head_div0 || ((head_op > OP_NOT) && (head_op != OP_RESET));
  assign head_in1     = head_use_acc ? acc_q : head_a;

  assign alu_opcode = alu_opcode_q;
  assign alu_in1    = alu_in1_q;
  assign alu_in2    = alu_in2_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_opcode = res_opcode_q;
  assign res_err    = res_err_q;

  // Write accepted commands into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op_q[wr_ptr_q]  <= cmd_opcode;
      fifo_a_q[wr_ptr_q]   <= cmd_a;
      fifo_b_q[wr_ptr_q]   <= cmd_b;
      fifo_acc_q[wr_ptr_q] <= cmd_use_acc;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sequencer: decode the head in IDLE, hold the ALU inputs for one ISSUE cycle,
  // then present the captured result until it is consumed.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q      <= ST_IDLE;
      alu_opcode_q <= OP_NOOP;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_opcode_q <= 4'h0;
      res_err_q    <= 1'b0;
      acc_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            if (head_div0) begin
              // Division by zero is answered locally with a flagged all-ones value.
              res_data_q   <= '1;
              res_opcode_q <= OP_DIV;
              res_err_q    <= 1'b1;
              res_valid_q  <= 1'b1;
              state_q      <= ST_RESP;
            end else if (head_legal) begin
              alu_opcode_q <= head_op;
              alu_in1_q    <= head_in1;
              alu_in2_q    <= head_b;
              state_q      <= ST_ISSUE;
            end else if (head_op == OP_RESET) begin
              acc_q <= '0;
            end
          end
        end
        ST_ISSUE: begin
          res_data_q   <= alu_out;
          res_opcode_q <= alu_opcode_q;
          res_err_q    <= 1'b0;
          res_valid_q  <= 1'b1;
          acc_q        <= alu_out;
          alu_opcode_q <= OP_NOOP;
          alu_in1_q    <= '0;
          alu_in2_q    <= '0;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_issued_q;
  logic [15:0] stat_dropped_q;
  logic [15:0] stat_issued_d;
  logic [15:0] stat_dropped_d;
  logic        issue_evt;
  logic        drop_evt;

  assign issue_evt = (state_q == ST_ISSUE);
  assign drop_evt  = pop && head_dropped;

  // Saturating increments for both statistics counters.
  always_comb begin
    stat_issued_d  = stat_issued_q;
    stat_dropped_d = stat_dropped_q;
    if (issue_evt && (stat_issued_q != 16'hFFFF)) stat_issued_d = stat_issued_q + 16'd1;
    if (drop_evt && (stat_dropped_q != 16'hFFFF)) stat_dropped_d = stat_dropped_q + 16'd1;
  end

  // Statistics registers, zeroed together with the rest of the block.
  always_ff @(posedge clk) begin
    if (clear) begin
      stat_issued_q  <= '0;
      stat_dropped_q <= '0;
    end else begin
      stat_issued_q  <= stat_issued_d;
      stat_dropped_q <= stat_dropped_d;
    end
  end

  assign stat_issued  = stat_issued_q;
  assign stat_dropped = stat_dropped_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: directed scenarios followed by randomized
// traffic, with a command-level reference model feeding two expectation queues
// (ALU issues and results) that a negedge monitor drains and compares.
`timescale 1ns/1ps

module tb_alu_op_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         clear = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [3:0]   cmd_opcode = 4'h0;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;
  logic         cmd_use_acc = 1'b0;
  logic [3:0]   alu_opcode;
  logic [W-1:0] alu_in1;
  logic [W-1:0] alu_in2;
  logic [W-1:0] alu_out;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_data;
  logic [3:0]   res_opcode;
  logic         res_err;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0]  stat_issued;
  logic [15:0]  stat_dropped;
`endif

  always #5 clk = ~clk;

  alu_op_sequencer #(.W(W), .DEPTH(4)) dut (
    .clk         (clk),
    .clear       (clear),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_opcode  (cmd_opcode),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_use_acc (cmd_use_acc),
    .alu_opcode  (alu_opcode),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_out     (alu_out),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_opcode  (res_opcode),
    .res_err     (res_err)
`ifdef ALU_SEQ_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_dropped(stat_dropped)
`endif
  );

  // Arithmetic of the 16-bit ALU; results truncated to W bits.
  function automatic logic [W-1:0] alu_f(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      4'h1:    return a + b;
      4'h2:    return a - b;
      4'h3:    return a * b;
      4'h4:    return (b == '0) ? '0 : a / b;
      4'h5:    return a & b;
      4'h6:    return a | b;
      4'h7:    return a ^ b;
      4'h8:    return ~a;
      default: return '0;
    endcase
  endfunction

  always_comb alu_out = alu_f(alu_opcode, alu_in1, alu_in2);

  int checks = 0;
  int failures = 0;
  bit rnd_rdy = 1'b0;
  logic [W-1:0]     acc_m = '0;
  logic [W+4:0]     exp_q[$];   // {data, opcode, err}
  logic [2*W+3:0]   iss_q[$];   // {opcode, in1, in2}

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference model applied to each accepted command, in acceptance order.
  task automatic model_cmd(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic ua);
    logic [W-1:0] ae;
    logic [W-1:0] r;
    if (op == 4'h4 && b == '0) begin
      exp_q.push_back({{W{1'b1}}, 4'h4, 1'b1});
    end else if (op >= 4'h1 && op <= 4'h8) begin
      ae = ua ? acc_m : a;
      r  = alu_f(op, ae, b);
      iss_q.push_back({op, ae, b});
      exp_q.push_back({r, op, 1'b0});
      acc_m = r;
    end else if (op == 4'hF) begin
      acc_m = '0;
    end
  endtask

  task automatic monitor();
    logic [W+4:0]   e;
    logic [2*W+3:0] ie;
    forever begin
      @(negedge clk);
      if (!clear) begin
        if (alu_opcode != 4'h0) begin
          if (iss_q.size() == 0) begin
            chk("unexpected_issue", 64'({alu_opcode, alu_in1, alu_in2}), 64'(0));
          end else begin
            ie = iss_q.pop_front();
            chk("issue", 64'({alu_opcode, alu_in1, alu_in2}), 64'(ie));
          end
        end else begin
          chk("idle_alu_inputs", 64'({alu_in1, alu_in2}), 64'(0));
        end
        if (res_valid && res_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 64'({res_data, res_opcode, res_err}), 64'(0));
          end else begin
            e = exp_q.pop_front();
            chk("result", 64'({res_data, res_opcode, res_err}), 64'(e));
          end
        end
      end
    end
  endtask

  task automatic do_clear();
    cmd_valid = 1'b0;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    exp_q.delete();
    iss_q.delete();
    acc_m = '0;
  endtask

  task automatic try_push(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ua, output bit ok);
    cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_valid = 1'b1;
    if (rnd_rdy) res_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    ok = cmd_ready;
    if (ok) model_cmd(op, a, b, ua);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic push(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ua);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) try_push(op, a, b, ua, ok);
    if (!ok) chk("push_timeout", 64'(0), 64'(1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      if (rnd_rdy) res_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    rnd_rdy = 1'b0;
    res_ready = 1'b1;
    for (int t = 0; t < 400; t++) begin
      if (exp_q.size() == 0 && iss_q.size() == 0 && !res_valid) break;
      @(posedge clk); #1;
    end
    repeat (4) begin @(posedge clk); #1; end
    chk("drain_queues_empty", 64'(exp_q.size() + iss_q.size()), 64'(0));
  endtask

  initial begin
    int n;
    bit ok;
    logic [3:0] op;
    logic [W-1:0] a, b;

    fork
      monitor();
    join_none

    // Reset state
    clear = 1'b1;
    repeat (2) @(posedge clk);
    #1 clear = 1'b0;
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rst_alu_opcode", 64'(alu_opcode), 64'(0));
    chk("rst_res_data", 64'(res_data), 64'(0));
    chk("rst_res_opcode", 64'(res_opcode), 64'(0));
    chk("rst_res_err", 64'(res_err), 64'(0));

    // ADD 3+4 with exact latency
    res_ready = 1'b1;
    push(4'h1, 16'd3, 16'd4, 1'b0);
    @(posedge clk); #1;
    chk("t1_alu_opcode", 64'(alu_opcode), 64'(1));
    chk("t1_alu_in1", 64'(alu_in1), 64'(3));
    chk("t1_alu_in2", 64'(alu_in2), 64'(4));
    chk("t1_res_valid_early", 64'(res_valid), 64'(0));
    @(posedge clk); #1;
    chk("t1_res_valid", 64'(res_valid), 64'(1));
    chk("t1_res_data", 64'(res_data), 64'(7));
    chk("t1_alu_opcode_after", 64'(alu_opcode), 64'(0));
    drain();

    // Accumulator chaining
    push(4'h1, 16'd5, 16'd6, 1'b0);
    push(4'h2, 16'd99, 16'd1, 1'b1);
    drain();

    // Divide by zero
    push(4'h4, 16'd8, 16'd0, 1'b0);
    drain();

    // Backpressure fills the FIFO
    res_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      try_push(4'h1, 16'(i * 10), 16'(i), 1'b0, ok);
      n = n + int'(ok);
    end
    chk("t4_accepted", 64'(n), 64'(5));
    chk("t4_cmd_ready_full", 64'(cmd_ready), 64'(0));
    drain();
    chk("t4_cmd_ready_after", 64'(cmd_ready), 64'(1));

    // Clear while a result is held
    res_ready = 1'b0;
    push(4'h1, 16'd1, 16'd1, 1'b0);
    push(4'h1, 16'd2, 16'd2, 1'b0);
    push(4'h1, 16'd3, 16'd3, 1'b0);
    for (int t = 0; t < 10 && !res_valid; t++) begin @(posedge clk); #1; end
    chk("t5_res_valid_held", 64'(res_valid), 64'(1));
    do_clear();
    chk("t5_res_valid", 64'(res_valid), 64'(0));
    chk("t5_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("t5_alu_opcode", 64'(alu_opcode), 64'(0));
    res_ready = 1'b1;
    push(4'h1, 16'd777, 16'd2, 1'b1);
    drain();

    // Undefined opcode, RESET, then accumulator ADD
    do_clear();
    res_ready = 1'b1;
    push(4'hA, 16'd5, 16'd5, 1'b0);
    push(4'hF, 16'd0, 16'd0, 1'b0);
    push(4'h1, 16'd50, 16'd1, 1'b1);
    drain();
`ifdef ALU_SEQ_STATS_EN
    chk("t6_stat_dropped", 64'(stat_dropped), 64'(1));
    chk("t6_stat_issued", 64'(stat_issued), 64'(1));
`endif

    // Randomized traffic
    rnd_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) < 10) op = 4'($urandom_range(1, 8));
      else op = 4'($urandom_range(0, 15));
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 5) == 0) b = '0;
      if ($urandom_range(0, 99) == 0) do_clear();
      push(op, a, b, 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
